// File: rtl/conv_fmap_pingpong_bram_if.sv
// conv_fmap_pingpong_bram_if
//   Producer/consumer bus of the ping-pong feature-map buffer.
//   master: the side driving strobes (producer + consumer layers).
//   slave : the buffer itself.
//   Producer: wr_en, wr_be, wr_addr, wr_data, wr_done -> wr_ready, wr_bank
//   Consumer: rd_en, rd_addr, rd_done -> rd_data, rd_valid, rd_ready, rd_bank
//   Status  : err (sticky protocol error)
interface conv_fmap_pingpong_bram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  wr_en;
    logic [DATA_W/8-1:0]   wr_be;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  wr_done;
    logic                  wr_ready;
    logic                  wr_bank;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  rd_done;
    logic                  rd_ready;
    logic                  rd_bank;
    logic                  err;

    modport master (
        output wr_en, wr_be, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        input  wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank, err
    );

    modport slave (
        input  wr_en, wr_be, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        output wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank, err
    );
endinterface

// File: rtl/conv_fmap_pingpong_bram.sv
// conv_fmap_pingpong_bram
//   Double-buffered feature-map store between two conv layers. The producer
//   fills one bank while the consumer reads the other; wr_done / rd_done hand
//   banks over. full_cnt counts banks that are complete and not yet released.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : slave side of conv_fmap_pingpong_bram_if (write port with
//                  byte enables, read port with RD_LAT latency, handshakes,
//                  sticky err)
//   RD_LAT = 2 adds an output register after the BRAM read register; any other
//   value behaves as RD_LAT = 1.
module conv_fmap_pingpong_bram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    conv_fmap_pingpong_bram_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    logic       wr_bank_q;
    logic       rd_bank_q;
    logic [1:0] full_cnt;
    logic       err_q;

    logic wr_ready, rd_ready;
    logic wr_acc, rd_acc, wr_hand, rd_hand, proto_err;

    assign wr_ready = (full_cnt != 2'd2);
    assign rd_ready = (full_cnt != 2'd0);

    assign wr_acc  = bus.wr_en   && wr_ready;
    assign rd_acc  = bus.rd_en   && rd_ready;
    assign wr_hand = bus.wr_done && wr_ready;
    assign rd_hand = bus.rd_done && rd_ready;

    // Any strobe aimed at a port that does not own a bank is dropped and flagged.
    assign proto_err = ((bus.wr_en || bus.wr_done) && !wr_ready) ||
                       ((bus.rd_en || bus.rd_done) && !rd_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_cnt  <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            if (wr_hand) wr_bank_q <= ~wr_bank_q;
            if (rd_hand) rd_bank_q <= ~rd_bank_q;
            // Simultaneous hand-over in both directions leaves the count alone.
            case ({wr_hand, rd_hand})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: full_cnt <= full_cnt;
            endcase
            if (proto_err) err_q <= 1'b1;
        end
    end

    // Storage: bank index is the address MSB. No reset so it maps to BRAM.
    // The ports always sit on different banks while both are active, so no
    // read-during-write collision handling is needed.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.wr_be[i]) begin
                    mem[{wr_bank_q, bus.wr_addr}][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    // BRAM read register; bank is sampled at issue, so a same-cycle rd_done
    // does not redirect the read. Loads only on an accepted read so the
    // output holds between beats.
    logic [DATA_W-1:0] ram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ram_q <= '0;
        else if (rd_acc) ram_q <= mem[{rd_bank_q, bus.rd_addr}];
    end

    // vld_pipe[k] marks data that is k+1 cycles past issue; reset flushes it.
    logic [((RD_LAT == 2) ? 2 : 1)-1:0] vld_pipe;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] out_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    out_q    <= '0;
                end else begin
                    vld_pipe <= {vld_pipe[0], rd_acc};
                    if (vld_pipe[0]) out_q <= ram_q;
                end
            end
            assign bus.rd_data  = out_q;
            assign bus.rd_valid = vld_pipe[1];
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vld_pipe <= '0;
                else        vld_pipe <= rd_acc;
            end
            assign bus.rd_data  = ram_q;
            assign bus.rd_valid = vld_pipe[0];
        end
    endgenerate

    assign bus.wr_ready = wr_ready;
    assign bus.rd_ready = rd_ready;
    assign bus.wr_bank  = wr_bank_q;
    assign bus.rd_bank  = rd_bank_q;
    assign bus.err      = err_q;
endmodule
